// File: rtl/multi_crop_stream_pkg.sv
// Shared types and helpers for the multi-window stream cropper.
// Holds the control-FSM state enum and the crop-window membership test.
package multi_crop_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_e;

    // True when (row,col) lies inside the h x w window anchored at (y,x).
    function automatic logic in_window(
        input int unsigned row,
        input int unsigned col,
        input int unsigned y,
        input int unsigned x,
        input int unsigned h,
        input int unsigned w
    );
        return (row >= y) && (row < y + h) &&
               (col >= x) && (col < x + w);
    endfunction

endpackage

// File: rtl/multi_crop_stream_if.sv
// AXI-Stream bundle: one pixel input stream and NUM_CROPS output streams.
// slave = cropper side, master = producer/consumer side.
interface multi_crop_stream_if #(
    parameter int PIXEL_BIT_WIDTH = 16,
    parameter int NUM_CROPS       = 4
);
    logic [PIXEL_BIT_WIDTH-1:0]           crop_input_TDATA;
    logic                                 crop_input_TVALID;
    logic                                 crop_input_TREADY;
    logic [NUM_CROPS*PIXEL_BIT_WIDTH-1:0] crop_output_TDATA;
    logic [NUM_CROPS-1:0]                 crop_output_TVALID;
    logic [NUM_CROPS-1:0]                 crop_output_TREADY;
    logic [NUM_CROPS-1:0]                 crop_output_TLAST;

    modport slave (
        input  crop_input_TDATA,
        input  crop_input_TVALID,
        output crop_input_TREADY,
        output crop_output_TDATA,
        output crop_output_TVALID,
        input  crop_output_TREADY,
        output crop_output_TLAST
    );

    modport master (
        output crop_input_TDATA,
        output crop_input_TVALID,
        input  crop_input_TREADY,
        input  crop_output_TDATA,
        input  crop_output_TVALID,
        output crop_output_TREADY,
        input  crop_output_TLAST
    );
endinterface

// File: rtl/multi_crop_stream_chan.sv
// One crop channel: window select, one-entry output register, TLAST.
// Ports: row/col position, latched origin/err, input handshake, out stream.
module crop_channel_reg
    import multi_crop_pkg::*;
#(
    parameter int PIXEL_BIT_WIDTH = 16,
    parameter int ROW_W           = 7,
    parameter int COL_W           = 8,
    parameter int OUT_ROWS        = 48,
    parameter int OUT_COLS        = 48
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [ROW_W-1:0]           row_i,
    input  logic [COL_W-1:0]           col_i,
    input  logic [ROW_W-1:0]           y_i,
    input  logic [COL_W-1:0]           x_i,
    input  logic                       err_i,
    input  logic                       acc_i,
    input  logic [PIXEL_BIT_WIDTH-1:0] data_i,
    input  logic                       ready_i,
    output logic                       sel_o,
    output logic                       valid_o,
    output logic                       last_o,
    output logic [PIXEL_BIT_WIDTH-1:0] data_o
);
    localparam int unsigned H = OUT_ROWS;
    localparam int unsigned W = OUT_COLS;

    logic                       valid_q, valid_d;
    logic                       last_q, last_d;
    logic [PIXEL_BIT_WIDTH-1:0] data_q, data_d;
    logic                       load;
    logic                       last_pix;

    assign sel_o = !err_i && in_window(32'(row_i), 32'(col_i),
                                       32'(y_i), 32'(x_i), H, W);

    assign last_pix = (32'(row_i) == 32'(y_i) + H - 1) &&
                      (32'(col_i) == 32'(x_i) + W - 1);

    assign load = acc_i && sel_o;

    // A reload in the same cycle as a drain keeps valid high with new data.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = data_i;
            last_d  = last_pix;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            last_q  <= last_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign last_o  = last_q;
    assign data_o  = data_q;

endmodule

// File: rtl/multi_crop_stream.sv
// Single-pass cropper emitting NUM_CROPS windows of one raster frame.
// Ports: ap_* control, crop_y/crop_x origins, crop_err, stream bundle io.
module multi_crop_stream
    import multi_crop_pkg::*;
#(
    parameter int PIXEL_BIT_WIDTH = 16,
    parameter int IN_ROWS         = 100,
    parameter int IN_COLS         = 160,
    parameter int OUT_ROWS        = 48,
    parameter int OUT_COLS        = 48,
    parameter int NUM_CROPS       = 4,
    parameter int ROW_W           = $clog2(IN_ROWS),
    parameter int COL_W           = $clog2(IN_COLS)
) (
    input  logic                       ap_clk,
    input  logic                       ap_rst,
    input  logic                       ap_start,
    output logic                       ap_idle,
    output logic                       ap_ready,
    output logic                       ap_done,
    input  logic [NUM_CROPS*ROW_W-1:0] crop_y,
    input  logic [NUM_CROPS*COL_W-1:0] crop_x,
    output logic [NUM_CROPS-1:0]       crop_err,
    multi_crop_stream_if.slave         io
);
    localparam int PW = PIXEL_BIT_WIDTH;

    state_e                             state_q, state_d;
    logic [ROW_W-1:0]                   row_q;
    logic [COL_W-1:0]                   col_q;
    logic [NUM_CROPS-1:0][ROW_W-1:0]    y_q;
    logic [NUM_CROPS-1:0][COL_W-1:0]    x_q;
    logic [NUM_CROPS-1:0]               err_q;
    logic                               ready_q;

    logic [NUM_CROPS-1:0]               err_c;
    logic [NUM_CROPS-1:0]               sel;
    logic [NUM_CROPS-1:0]               valid;
    logic [NUM_CROPS-1:0]               last;
    logic [NUM_CROPS-1:0][PW-1:0]       data;
    logic                               in_rdy;
    logic                               acc;
    logic                               last_pix;
    logic                               go;

    assign go       = (state_q == IDLE) && ap_start;
    assign acc      = io.crop_input_TVALID && in_rdy;
    assign last_pix = (row_q == ROW_W'(IN_ROWS - 1)) &&
                      (col_q == COL_W'(IN_COLS - 1));

    // A channel blocks input only if this pixel targets it and its
    // register is full and not draining this cycle.
    assign in_rdy = (state_q == RUN) &&
                    (&(~sel | ~valid | io.crop_output_TREADY));

    always_comb begin
        state_d = state_q;
        ap_idle = 1'b0;
        ap_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                ap_idle = 1'b1;
                if (ap_start) state_d = RUN;
            end
            RUN: begin
                if (acc && last_pix) state_d = DRAIN;
            end
            DRAIN: begin
                if (valid == '0) state_d = DONE;
            end
            DONE: begin
                ap_done = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            y_q     <= '0;
            x_q     <= '0;
            err_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= acc && last_pix;
            if (go) begin
                y_q   <= crop_y;
                x_q   <= crop_x;
                err_q <= err_c;
                row_q <= '0;
                col_q <= '0;
            end else if (acc) begin
                if (col_q == COL_W'(IN_COLS - 1)) begin
                    col_q <= '0;
                    row_q <= row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_CROPS; k++) begin : g_ch
        logic [ROW_W:0] ysum;
        logic [COL_W:0] xsum;

        // One extra bit so y+OUT_ROWS cannot wrap before the compare.
        assign ysum = {1'b0, crop_y[k*ROW_W +: ROW_W]} +
                      (ROW_W+1)'(OUT_ROWS);
        assign xsum = {1'b0, crop_x[k*COL_W +: COL_W]} +
                      (COL_W+1)'(OUT_COLS);
        assign err_c[k] = (ysum > (ROW_W+1)'(IN_ROWS)) ||
                          (xsum > (COL_W+1)'(IN_COLS));

        crop_channel_reg #(
            .PIXEL_BIT_WIDTH (PW),
            .ROW_W           (ROW_W),
            .COL_W           (COL_W),
            .OUT_ROWS        (OUT_ROWS),
            .OUT_COLS        (OUT_COLS)
        ) u_ch (
            .clk_i   (ap_clk),
            .rst_i   (ap_rst),
            .row_i   (row_q),
            .col_i   (col_q),
            .y_i     (y_q[k]),
            .x_i     (x_q[k]),
            .err_i   (err_q[k]),
            .acc_i   (acc),
            .data_i  (io.crop_input_TDATA),
            .ready_i (io.crop_output_TREADY[k]),
            .sel_o   (sel[k]),
            .valid_o (valid[k]),
            .last_o  (last[k]),
            .data_o  (data[k])
        );
    end

    assign ap_ready              = ready_q;
    assign crop_err              = err_q;
    assign io.crop_input_TREADY  = in_rdy;
    assign io.crop_output_TVALID = valid;
    assign io.crop_output_TLAST  = last;
    assign io.crop_output_TDATA  = data;

endmodule

// File: tb/tb_multi_crop_stream.sv
// Self-checking bench for multi_crop_stream against a window-list model.
// Covers reset, mid-frame reset, stall, ignored restart, errors, random flow.
module tb_multi_crop_stream;
    localparam int PW   = 16;
    localparam int IR   = 100;
    localparam int IC   = 160;
    localparam int OR_  = 48;
    localparam int OC   = 48;
    localparam int N    = 4;
    localparam int RW   = 7;
    localparam int CW   = 8;
    localparam int NPIX = IR * IC;

    typedef struct {
        logic [PW-1:0] d;
        logic          l;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            idle, rdy, done;
    logic [N*RW-1:0] cy;
    logic [N*CW-1:0] cx;
    logic [N-1:0]    err;

    multi_crop_stream_if #(.PIXEL_BIT_WIDTH(PW), .NUM_CROPS(N)) bus ();

    multi_crop_stream #(
        .PIXEL_BIT_WIDTH (PW),
        .IN_ROWS         (IR),
        .IN_COLS         (IC),
        .OUT_ROWS        (OR_),
        .OUT_COLS        (OC),
        .NUM_CROPS       (N)
    ) dut (
        .ap_clk   (clk),
        .ap_rst   (rst),
        .ap_start (start),
        .ap_idle  (idle),
        .ap_ready (rdy),
        .ap_done  (done),
        .crop_y   (cy),
        .crop_x   (cx),
        .crop_err (err),
        .io       (bus)
    );

    always #5 clk = ~clk;

    exp_t          expq[N][$];
    logic [PW-1:0] pix[NPIX];
    int            oy[N], ox[N];
    logic [N-1:0]  exp_err;
    int            n_chk = 0, n_fail = 0;
    int            done_cnt = 0, rdy_cnt = 0;
    int            last_cnt[N], n_out[N];
    logic [PW-1:0] first_d[N], last_d[N];
    int            rmode = 0;
    logic [N-1:0]  rmask = '1;
    logic [N-1:0]  prev_hold = '0;
    logic [PW-1:0] prev_d[N];
    logic          prev_l[N];
    logic [PW-1:0] md;
    logic          ml;
    exp_t          em;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output-side scoreboard: every handshake must match the model head.
    always @(negedge clk) begin
        if (rst) begin
            prev_hold = '0;
        end else begin
            if (done) done_cnt++;
            if (rdy) rdy_cnt++;
            for (int k = 0; k < N; k++) begin
                md = bus.crop_output_TDATA[k*PW +: PW];
                ml = bus.crop_output_TLAST[k];
                if (prev_hold[k])
                    chk($sformatf("ch%0d_hold", k),
                        32'({bus.crop_output_TVALID[k], ml, md}),
                        32'({1'b1, prev_l[k], prev_d[k]}));
                if (bus.crop_output_TVALID[k] &&
                    bus.crop_output_TREADY[k]) begin
                    n_chk++;
                    assert (expq[k].size() != 0) else begin
                        n_fail++;
                        $error("FAIL ch%0d_extra: observed %0h expected none",
                               k, md);
                    end
                    if (expq[k].size() != 0) begin
                        em = expq[k].pop_front();
                        chk($sformatf("ch%0d_data", k),
                            32'({ml, md}), 32'({em.l, em.d}));
                        if (n_out[k] == 0) first_d[k] = md;
                        last_d[k] = md;
                        n_out[k]++;
                        if (ml) last_cnt[k]++;
                    end
                end
                prev_hold[k] = bus.crop_output_TVALID[k] &
                               !bus.crop_output_TREADY[k];
                prev_d[k] = md;
                prev_l[k] = ml;
            end
        end
    end

    task automatic drive_ready();
        for (int k = 0; k < N; k++)
            bus.crop_output_TREADY[k] = rmask[k] &
                ((rmode == 0) || ($urandom_range(1) == 1));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        drive_ready();
    endtask

    // Expected crop contents straight from the window definitions.
    task automatic build_model();
        exp_t e;
        done_cnt = 0;
        rdy_cnt  = 0;
        for (int k = 0; k < N; k++) begin
            expq[k].delete();
            last_cnt[k] = 0;
            n_out[k]    = 0;
            exp_err[k]  = (oy[k] + OR_ > IR) || (ox[k] + OC > IC);
            cy[k*RW +: RW] = RW'(oy[k]);
            cx[k*CW +: CW] = CW'(ox[k]);
            if (!exp_err[k])
                for (int r = oy[k]; r < oy[k] + OR_; r++)
                    for (int c = ox[k]; c < ox[k] + OC; c++) begin
                        e.d = pix[r*IC + c];
                        e.l = (r == oy[k] + OR_ - 1) &&
                              (c == ox[k] + OC - 1);
                        expq[k].push_back(e);
                    end
        end
    endtask

    task automatic start_frame();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("crop_err_latched", 32'(err), 32'(exp_err));
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int n_send, input int pct,
                              input int stall_idx, input int pulse_idx,
                              input int max_cyc);
        int idx = 0;
        int cn = 0;
        int hold = 0;
        bit stalled = 0;
        bit pulsed = 0;
        bit acc;
        while (idx < n_send && cn < max_cyc) begin
            if (idx == stall_idx && !stalled) begin
                hold = 200;
                stalled = 1;
            end
            rmask[0] = (hold == 0);
            drive_ready();
            bus.crop_input_TVALID = ($urandom_range(99) < pct);
            bus.crop_input_TDATA  = pix[idx];
            if (idx == pulse_idx && !pulsed) begin
                start  = 1'b1;
                pulsed = 1;
                cy     = {N{7'd99}};
                cx     = {N{8'd159}};
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            acc = bus.crop_input_TVALID && bus.crop_input_TREADY;
            if (hold == 1) begin
                chk("stall_in_ready", 32'(bus.crop_input_TREADY), 0);
                chk("stall_idx", 32'(idx), 32'(stall_idx));
                chk("stall_ch0_data", 32'(bus.crop_output_TDATA[PW-1:0]),
                    32'(pix[stall_idx-1]));
            end
            if (hold > 0) hold--;
            @(posedge clk);
            #1;
            if (acc) idx++;
            cn++;
        end
        start = 1'b0;
        bus.crop_input_TVALID = 1'b0;
        rmask = '1;
        drive_ready();
        chk("send_complete", 32'(idx), 32'(n_send));
    endtask

    task automatic wait_done(input int max_cyc);
        int c = 0;
        while (done_cnt == 0 && c < max_cyc) begin
            cyc();
            c++;
        end
        repeat (3) cyc();
        chk("done_once", 32'(done_cnt), 1);
        chk("idle_after", 32'(idle), 1);
        chk("ready_once", 32'(rdy_cnt), 1);
        chk("err_kept", 32'(err), 32'(exp_err));
        for (int k = 0; k < N; k++) begin
            chk($sformatf("ch%0d_left", k), 32'(expq[k].size()), 0);
            chk($sformatf("ch%0d_count", k), 32'(n_out[k]),
                exp_err[k] ? 0 : OR_ * OC);
            chk($sformatf("ch%0d_tlast", k), 32'(last_cnt[k]),
                exp_err[k] ? 0 : 1);
        end
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_idle"}, 32'(idle), 1);
        chk({tag, "_ready"}, 32'(rdy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_in_tready"}, 32'(bus.crop_input_TREADY), 0);
        chk({tag, "_tvalid"}, 32'(bus.crop_output_TVALID), 0);
        chk({tag, "_tlast"}, 32'(bus.crop_output_TLAST), 0);
        chk({tag, "_tdata"}, 32'(|bus.crop_output_TDATA), 0);
        chk({tag, "_err"}, 32'(err), 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        cy    = '0;
        cx    = '0;
        bus.crop_input_TVALID  = 1'b0;
        bus.crop_input_TDATA   = '0;
        bus.crop_output_TREADY = '1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_cleared("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Frame A: reset lands mid-frame after 5000 pixels.
        for (int i = 0; i < NPIX; i++) pix[i] = PW'(i);
        oy = '{10, 0, 52, 30};
        ox = '{10, 0, 112, 40};
        build_model();
        start_frame();
        send_frame(5000, 100, -1, -1, 20000);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_cleared("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < N; k++) expq[k].delete();
        done_cnt = 0;
        repeat (20) cyc();
        chk("no_done_after_rst", 32'(done_cnt), 0);

        // Frame B: full frame, ch0 stall, ignored ap_start in RUN.
        build_model();
        start_frame();
        send_frame(NPIX, 100, 1620, 8000, 40000);
        @(negedge clk);
        chk("ap_ready_pulse", 32'(rdy), 1);
        @(posedge clk);
        #1;
        wait_done(500);
        chk("ch0_first", 32'(first_d[0]), 1610);
        chk("ch2_last", 32'(last_d[2]), 15999);

        // Frame C: random data/flow, overlap, channel 1 out of frame.
        for (int i = 0; i < NPIX; i++) pix[i] = PW'($urandom);
        oy = '{10, 60, 20, 52};
        ox = '{10, 0, 20, 112};
        rmode = 1;
        build_model();
        start_frame();
        send_frame(NPIX, 50, -1, -1, 80000);
        @(negedge clk);
        chk("ap_ready_pulse_rnd", 32'(rdy), 1);
        @(posedge clk);
        #1;
        wait_done(2000);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
